// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART_Tx-side signals of the shared-transmitter arbiter.
// master = requesters + UART environment, slave = the arbiter itself.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      busy;
    logic                      err;
    logic                      tx_en;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_rfn;

    modport master (
        output req, req_lock, req_data, tx_rfn,
        input  gnt, busy, err, tx_en, tx_data
    );

    modport slave (
        input  req, req_lock, req_data, tx_rfn,
        output gnt, busy, err, tx_en, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_Tx among NUM_REQ requesters, with
// per-requester packet lock and launch pacing on the transmitter's RFN flag.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input logic              clk,
    input logic              rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_HIGH} state_t;

    state_t                         state, state_nx;
    logic [IW-1:0]                  ptr, ptr_nx, owner, owner_nx, win, idx;
    logic [CW-1:0]                  cnt, cnt_nx;
    logic                           found;
    logic [NUM_REQ-1:0][DATA_W-1:0] bytes;

    logic [NUM_REQ-1:0] gnt_q, gnt_nx;
    logic [DATA_W-1:0]  tx_data_q, tx_data_nx;
    logic               tx_en_q, tx_en_nx, err_q, err_nx, busy_q;

    assign bytes       = bus.req_data;
    assign bus.gnt     = gnt_q;
    assign bus.tx_en   = tx_en_q;
    assign bus.tx_data = tx_data_q;
    assign bus.err     = err_q;
    assign bus.busy    = busy_q;

    // A held lock pins the grant to the previous owner; otherwise rotate from ptr.
    always_comb begin
        win   = ptr;
        idx   = '0;
        found = 1'b0;
        if (bus.req[owner] && bus.req_lock[owner]) begin
            win = owner;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = ptr + IW'(k);
                if (!found && bus.req[idx]) begin
                    win   = idx;
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        owner_nx   = owner;
        cnt_nx     = cnt;
        gnt_nx     = '0;
        tx_en_nx   = 1'b0;
        err_nx     = 1'b0;
        tx_data_nx = tx_data_q;
        case (state)
            IDLE: begin
                if (bus.tx_rfn && |bus.req) begin
                    state_nx    = WAIT_LOW;
                    tx_en_nx    = 1'b1;
                    gnt_nx[win] = 1'b1;
                    tx_data_nx  = bytes[win];
                    owner_nx    = win;
                    ptr_nx      = win + IW'(1);
                    cnt_nx      = '0;
                end
            end
            WAIT_LOW: begin
                // RFN must fall to prove the transmitter took the byte.
                if (!bus.tx_rfn) begin
                    state_nx = WAIT_HIGH;
                    cnt_nx   = '0;
                end else if (cnt == CW'(TIMEOUT)) begin
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            WAIT_HIGH: begin
                if (bus.tx_rfn) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            cnt       <= '0;
            gnt_q     <= '0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            owner     <= owner_nx;
            cnt       <= cnt_nx;
            gnt_q     <= gnt_nx;
            tx_en_q   <= tx_en_nx;
            tx_data_q <= tx_data_nx;
            err_q     <= err_nx;
            busy_q    <= (state_nx != IDLE);
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: behavioural UART_Tx RFN model plus a
// scoreboard of expected {gnt, byte} launches.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic uart_rfn;
    bit   uart_live = 1'b1;
    bit   rfn_block = 1'b0;
    int   frame_len = 12500;
    int   checks = 0, passed = 0, fails = 0;
    int   cyc = 0;
    int   t_launch = 0;
    exp_t sb[$];

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.tx_rfn = uart_rfn & ~rfn_block;

    // UART_Tx stand-in: RFN falls one cycle after seeing Tx_EN, stays low a frame.
    initial begin
        uart_rfn = 1'b1;
        forever begin
            @(negedge clk);
            if (uart_live && bus.tx_en) begin
                @(negedge clk);
                uart_rfn = 1'b0;
                repeat (frame_len) @(negedge clk);
                uart_rfn = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_gnt"},     32'(bus.gnt),     0);
        chk({tag, "_busy"},    32'(bus.busy),    0);
        chk({tag, "_err"},     32'(bus.err),     0);
        chk({tag, "_tx_en"},   32'(bus.tx_en),   0);
        chk({tag, "_tx_data"}, 32'(bus.tx_data), 0);
    endtask

    // Waits for a tx_en pulse, scores it against the queue head, checks it is 1 cycle.
    task automatic wait_launch(input string tag, input int max_cyc, output int lat);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < max_cyc) begin
            @(negedge clk);
            lat++;
            if (bus.tx_en) seen = 1'b1;
        end
        chk({tag, "_seen"}, 32'(seen), 1);
        if (seen) begin
            t_launch = cyc;
            chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({tag, "_gnt"},     32'(bus.gnt),     32'(e.gnt));
                chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'(e.data));
            end
            chk({tag, "_err_quiet"}, 32'(bus.err), 0);
            @(negedge clk);
            chk({tag, "_tx_en_pulse"}, 32'(bus.tx_en), 0);
            chk({tag, "_gnt_pulse"},   32'(bus.gnt),   0);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy && n < 500);
        chk({tag, "_idle"}, 32'(bus.busy), 0);
    endtask

    task automatic wait_rfn(input logic val, input int max_cyc, output bit got);
        int n;
        n   = 0;
        got = 1'b0;
        while (!got && n < max_cyc) begin
            @(posedge clk);
            n++;
            got = (bus.tx_rfn === val);
        end
    endtask

    initial begin
        int   lat, early, t_err;
        bit   got;
        logic [7:0] lk_bytes [3];
        lk_bytes[0] = 8'hFB;
        lk_bytes[1] = 8'h1D;
        lk_bytes[2] = 8'hE4;

        bus.req      = '0;
        bus.req_lock = '0;
        bus.req_data = '0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single request, full-length 9600-baud frame.
        bus.req_data[7:0] = 8'hAF;
        bus.req           = 4'b0001;
        sb.push_back({4'b0001, 8'hAF});
        wait_launch("single", 5, lat);
        chk("single_lat", 32'(lat), 1);
        bus.req = '0;
        chk("single_busy", 32'(bus.busy), 1);
        wait_rfn(1'b0, 10, got);
        chk("single_rfn_fell", 32'(got), 1);
        wait_rfn(1'b1, 13000, got);
        chk("single_rfn_rose", 32'(got), 1);
        @(negedge clk);
        chk("single_busy_drop", 32'(bus.busy), 0);
        frame_len = 40;

        // Round robin from a fresh pointer.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.req_data = 32'h44332211;
        bus.req      = 4'b1111;
        for (int i = 0; i < 5; i++) sb.push_back({4'(1 << (i % 4)), 8'(8'h11 * ((i % 4) + 1))});
        for (int i = 0; i < 5; i++) wait_launch($sformatf("rr%0d", i), 200, lat);
        bus.req = '0;
        wait_idle("rr");

        // Lock keeps requester 0 ahead of requester 2, then round robin resumes.
        bus.req_data       = '0;
        bus.req_data[23:16] = 8'h5C;
        bus.req_data[7:0]   = lk_bytes[0];
        bus.req_lock        = 4'b0001;
        bus.req             = 4'b0101;
        for (int i = 0; i < 3; i++) sb.push_back({4'b0001, lk_bytes[i]});
        for (int i = 0; i < 3; i++) begin
            wait_launch($sformatf("lock%0d", i), 200, lat);
            if (i < 2) bus.req_data[7:0] = lk_bytes[i + 1];
        end
        bus.req_lock = '0;
        sb.push_back({4'b0100, 8'h5C});
        wait_launch("unlock", 200, lat);
        bus.req = '0;
        wait_idle("lock");

        // Backpressure: RFN low at idle must hold off the launch.
        rfn_block          = 1'b1;
        bus.req_data[15:8] = 8'h23;
        bus.req            = 4'b0010;
        early = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.tx_en) early++;
        end
        chk("bp_no_launch", 32'(early), 0);
        sb.push_back({4'b0010, 8'h23});
        rfn_block = 1'b0;
        wait_launch("bp", 5, lat);
        chk("bp_lat", 32'(lat), 1);
        bus.req = '0;
        wait_idle("bp");

        // Timeout: UART never acknowledges; pointer sits at 2 after granting 1.
        uart_live          = 1'b0;
        bus.req_data[7:0]  = 8'hA0;
        bus.req_data[31:24] = 8'hD0;
        bus.req            = 4'b1001;
        sb.push_back({4'b1000, 8'hD0});
        wait_launch("to", 5, lat);
        got = 1'b0;
        t_err = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (bus.err) begin
                got   = 1'b1;
                t_err = cyc;
            end
        end
        chk("to_err_seen", 32'(got), 1);
        chk("to_err_delay", 32'(t_err - t_launch), TIMEOUT + 1);
        sb.push_back({4'b0001, 8'hA0});
        uart_live = 1'b1;
        wait_launch("to_next", 5, lat);
        chk("to_next_lat", 32'(lat), 1);
        bus.req = '0;
        wait_idle("to");

        // Reset in WAIT_HIGH; relaunch only once the in-flight frame ends.
        frame_len           = 300;
        bus.req_data[23:16] = 8'h77;
        bus.req             = 4'b0100;
        sb.push_back({4'b0100, 8'h77});
        wait_launch("mid", 200, lat);
        bus.req = '0;
        repeat (20) @(negedge clk);
        chk("mid_busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("mid_rst");
        repeat (2) @(negedge clk);
        rst_n              = 1'b1;
        bus.req_data[15:8] = 8'h99;
        bus.req            = 4'b0010;
        early = 0;
        got   = 1'b0;
        for (int n = 0; n < 400 && !got; n++) begin
            @(posedge clk);
            if (bus.tx_en) early++;
            got = bus.tx_rfn;
        end
        chk("mid_hold", 32'(early), 0);
        chk("mid_rfn_rose", 32'(got), 1);
        sb.push_back({4'b0010, 8'h99});
        wait_launch("mid_relaunch", 5, lat);
        chk("mid_relaunch_lat", 32'(lat), 1);
        bus.req = '0;
        wait_idle("mid");

        chk("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
